// File: rtl/lag_pl_tile_injector.sv
// lag_pl_tile_injector: segments packet descriptors into flits and drives the router TILE port
// with per-link credit flow control. Per-link flit layout, MSB first: {valid, head, tail, dest_x, dest_y, data}.
`ifndef NORTH
`define NORTH 0
`endif
`ifndef EAST
`define EAST 1
`endif
`ifndef SOUTH
`define SOUTH 2
`endif
`ifndef WEST
`define WEST 3
`endif
`ifndef TILE
`define TILE 4
`endif

module lag_pl_tile_injector #(
    parameter int network_x = 4,
    parameter int network_y = 4,
    parameter int my_x      = 0,
    parameter int my_y      = 0,
    parameter int num_pls   = 1,
    parameter int buf_len   = 4,
    parameter int len_bits  = 4,
    localparam int RADIX    = 5,
    localparam int XW       = (network_x > 1) ? $clog2(network_x) : 1,
    localparam int YW       = (network_y > 1) ? $clog2(network_y) : 1,
    localparam int DW       = (len_bits > RADIX) ? len_bits : RADIX,
    localparam int FW       = 3 + XW + YW + DW,
    localparam int CW       = $clog2(buf_len + 1),
    localparam int PW       = (num_pls > 1) ? $clog2(num_pls) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [XW-1:0]         i_req_dest_x,
    input  logic [YW-1:0]         i_req_dest_y,
    input  logic [len_bits-1:0]   i_req_len,
    output logic [num_pls*FW-1:0] o_flit_out,
    input  logic [num_pls-1:0]    i_cntrl_in,
    input  logic [num_pls-1:0]    i_full_flag,
    output logic                  o_busy,
    output logic                  o_credit_err,
    output logic [31:0]           o_pkts_sent,
    output logic [num_pls*CW-1:0] o_credits
);
    typedef enum logic [1:0] {IDLE, SELECT, SEND} state_t;

    localparam logic [XW-1:0] MY_X      = XW'(my_x);
    localparam logic [YW-1:0] MY_Y      = YW'(my_y);
    localparam logic [CW-1:0] FULL_CRED = CW'(buf_len);

    state_t              r_state;
    logic [XW-1:0]       r_dx;
    logic [YW-1:0]       r_dy;
    logic [len_bits-1:0] r_len;
    logic [len_bits-1:0] r_idx;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_pl;
    logic                r_err;
    logic [31:0]         r_pkts;
    logic [CW-1:0]       r_cred [num_pls];
    logic [FW-1:0]       r_flit [num_pls];

    logic [num_pls-1:0]  w_elig;
    logic [num_pls-1:0]  w_send;
    logic                w_rr_ok;
    logic                w_issue;
    logic                w_head;
    logic                w_tail;
    logic [PW-1:0]       w_rr_pl;
    logic [PW-1:0]       w_pl;
    logic [len_bits-1:0] w_seq;
    logic [RADIX-1:0]    w_port;
    logic [FW-1:0]       w_flit;

    always_comb begin
        w_elig = '0;
        w_send = '0;
        for (int p = 0; p < num_pls; p++) begin
            w_elig[p] = (r_cred[p] != '0) && !i_full_flag[p];
            w_send[p] = w_issue && (w_pl == PW'(p));
        end
    end

    // Scanning downward lets the eligible link closest after the pointer win.
    always_comb begin
        w_rr_ok = 1'b0;
        w_rr_pl = '0;
        for (int k = num_pls - 1; k >= 0; k--) begin
            if (w_elig[PW'((int'(r_ptr) + k) % num_pls)]) begin
                w_rr_ok = 1'b1;
                w_rr_pl = PW'((int'(r_ptr) + k) % num_pls);
            end
        end
    end

    assign w_head  = (r_state == SELECT);
    assign w_pl    = w_head ? w_rr_pl : r_pl;
    assign w_issue = w_head ? w_rr_ok : (r_state == SEND) && w_elig[r_pl];
    assign w_seq   = w_head ? '0 : r_idx;
    assign w_tail  = (w_seq == r_len - len_bits'(1));
    assign w_port  = (r_dx > MY_X) ? RADIX'(1 << `EAST)  :
                     (r_dx < MY_X) ? RADIX'(1 << `WEST)  :
                     (r_dy > MY_Y) ? RADIX'(1 << `SOUTH) :
                     (r_dy < MY_Y) ? RADIX'(1 << `NORTH) : RADIX'(1 << `TILE);
    assign w_flit  = {1'b1, w_head, w_tail, r_dx, r_dy, w_head ? DW'(w_port) : DW'(w_seq)};

    assign o_req_ready  = rst_n && (r_state == IDLE);
    assign o_busy       = (r_state != IDLE);
    assign o_credit_err = r_err;
    assign o_pkts_sent  = r_pkts;

    for (genvar g = 0; g < num_pls; g++) begin : g_out
        assign o_flit_out[g*FW +: FW] = r_flit[g];
        assign o_credits[g*CW +: CW]  = r_cred[g];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dx    <= '0;
            r_dy    <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_pl    <= '0;
            r_err   <= 1'b0;
            r_pkts  <= '0;
            for (int p = 0; p < num_pls; p++) begin
                r_cred[p] <= FULL_CRED;
                r_flit[p] <= '0;
            end
        end else begin
            for (int p = 0; p < num_pls; p++) begin
                r_flit[p] <= w_send[p] ? w_flit : '0;
                if (w_send[p] && !i_cntrl_in[p])
                    r_cred[p] <= r_cred[p] - CW'(1);
                else if (!w_send[p] && i_cntrl_in[p]) begin
                    if (r_cred[p] == FULL_CRED)
                        r_err <= 1'b1;
                    else
                        r_cred[p] <= r_cred[p] + CW'(1);
                end
            end
            case (r_state)
                IDLE: if (i_req_valid) begin
                    r_dx    <= i_req_dest_x;
                    r_dy    <= i_req_dest_y;
                    r_len   <= (i_req_len == '0) ? len_bits'(1) : i_req_len;
                    r_state <= SELECT;
                end
                SELECT: if (w_rr_ok) begin
                    r_pl    <= w_rr_pl;
                    r_ptr   <= (w_rr_pl == PW'(num_pls - 1)) ? '0 : w_rr_pl + PW'(1);
                    r_idx   <= len_bits'(1);
                    r_state <= w_tail ? IDLE : SEND;
                    if (w_tail) r_pkts <= r_pkts + 32'd1;
                end
                SEND: if (w_issue) begin
                    r_idx <= r_idx + len_bits'(1);
                    if (w_tail) begin
                        r_state <= IDLE;
                        r_pkts  <= r_pkts + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lag_pl_tile_injector.sv
// tb_lag_pl_tile_injector: randomized traffic, credit returns and back-pressure against a
// packet-queue reference model of the tile injector.
module tb_lag_pl_tile_injector;
    localparam int NX = 4, NY = 4, MX = 1, MY = 1, NP = 2, BL = 4, LB = 4;
    localparam int XW = 2, YW = 2, DW = 5, FW = 3 + XW + YW + DW, CW = 3;
    localparam int P_N = 0, P_E = 1, P_S = 2, P_W = 3, P_T = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [XW-1:0]     req_dest_x = '0;
    logic [YW-1:0]     req_dest_y = '0;
    logic [LB-1:0]     req_len = '0;
    logic [NP*FW-1:0]  flit_out;
    logic [NP-1:0]     cntrl_in = '0;
    logic [NP-1:0]     full_flag = '0;
    logic              busy;
    logic              credit_err;
    logic [31:0]       pkts_sent;
    logic [NP*CW-1:0]  credits;

    always #5 clk = ~clk;

    lag_pl_tile_injector #(
        .network_x(NX), .network_y(NY), .my_x(MX), .my_y(MY),
        .num_pls(NP), .buf_len(BL), .len_bits(LB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_dest_x(req_dest_x), .i_req_dest_y(req_dest_y), .i_req_len(req_len),
        .o_flit_out(flit_out), .i_cntrl_in(cntrl_in), .i_full_flag(full_flag),
        .o_busy(busy), .o_credit_err(credit_err), .o_pkts_sent(pkts_sent),
        .o_credits(credits)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: every accepted packet is expanded into its full flit list up front.
    logic [FW-1:0] q[$];
    logic [FW-1:0] exp_flit [NP];
    int            m_cred [NP];
    int            m_ptr, m_pl, exp_pkts, cyc;
    bit            started, exp_err, want_rst;

    function automatic int route(int x, int y);
        if (x > MX) return P_E;
        if (x < MX) return P_W;
        if (y > MY) return P_S;
        if (y < MY) return P_N;
        return P_T;
    endfunction

    task automatic push_pkt(input int x, input int y, input int l);
        int n;
        logic [DW-1:0] d;
        n = (l == 0) ? 1 : l;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? DW'(1 << route(x, y)) : DW'(i);
            q.push_back({1'b1, i == 0, i == n - 1, XW'(x), YW'(y), d});
        end
    endtask

    task automatic model_reset();
        q.delete();
        started  = 0;
        m_ptr    = 0;
        m_pl     = 0;
        exp_pkts = 0;
        exp_err  = 0;
        for (int p = 0; p < NP; p++) begin
            m_cred[p]   = BL;
            exp_flit[p] = '0;
        end
    endtask

    task automatic step();
        bit [NP-1:0] el;
        int sp, j;
        bit idle;
        logic [FW-1:0] f;
        idle = (q.size() == 0);
        sp = -1;
        for (int p = 0; p < NP; p++) el[p] = (m_cred[p] > 0) && !full_flag[p];
        if (!idle) begin
            if (!started) begin
                for (int k = 0; k < NP; k++) begin
                    j = (m_ptr + k) % NP;
                    if (sp < 0 && el[j]) sp = j;
                end
                if (sp >= 0) begin
                    m_pl = sp;
                    m_ptr = (sp + 1) % NP;
                    started = 1;
                end
            end else if (el[m_pl]) sp = m_pl;
        end
        for (int p = 0; p < NP; p++) exp_flit[p] = '0;
        if (sp >= 0) begin
            f = q.pop_front();
            exp_flit[sp] = f;
            if (f[FW-3]) begin
                exp_pkts++;
                started = 0;
            end
        end
        if (idle && req_valid) push_pkt(int'(req_dest_x), int'(req_dest_y), int'(req_len));
        for (int p = 0; p < NP; p++) begin
            if (sp == p && !cntrl_in[p]) m_cred[p]--;
            else if (sp != p && cntrl_in[p]) begin
                if (m_cred[p] == BL) exp_err = 1;
                else m_cred[p]++;
            end
        end
    endtask

    task automatic compare();
        for (int p = 0; p < NP; p++) begin
            check($sformatf("flit_pl%0d@%0d", p, cyc), 64'(flit_out[p*FW +: FW]), 64'(exp_flit[p]));
            check($sformatf("credit_pl%0d@%0d", p, cyc), 64'(credits[p*CW +: CW]), 64'(m_cred[p]));
        end
        check($sformatf("req_ready@%0d", cyc), 64'(req_ready), 64'(q.size() == 0));
        check($sformatf("busy@%0d", cyc), 64'(busy), 64'(q.size() != 0));
        check($sformatf("pkts_sent@%0d", cyc), 64'(pkts_sent), 64'(exp_pkts));
        check($sformatf("credit_err@%0d", cyc), 64'(credit_err), 64'(exp_err));
    endtask

    task automatic drive();
        int ret, full;
        bit spur;
        ret  = (cyc < 300) ? 60 : (cyc < 450) ? 0 : (cyc < 600) ? 10 : (cyc < 900) ? 50 : 40;
        full = (cyc >= 900) ? 15 : 0;
        spur = (cyc >= 900);
        req_valid  = ($urandom_range(0, 99) < 70);
        req_dest_x = XW'($urandom_range(0, NX - 1));
        req_dest_y = YW'($urandom_range(0, NY - 1));
        req_len    = ($urandom_range(0, 3) == 0) ? LB'($urandom_range(0, 15)) : LB'($urandom_range(0, 3));
        for (int p = 0; p < NP; p++) begin
            full_flag[p] = (cyc >= 600 && cyc < 900) ? (p == 0) : ($urandom_range(0, 99) < full);
            cntrl_in[p]  = (m_cred[p] < BL) ? ($urandom_range(0, 99) < ret)
                                            : (spur && $urandom_range(0, 99) < 3);
        end
    endtask

    initial begin
        model_reset();
        want_rst = 0;
        cyc = -1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        for (cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
                #1;
            end
            compare();
            if (cyc >= 900 && cyc % 150 == 0) want_rst = 1;
            if (want_rst && started && q.size() > 1) begin
                want_rst  = 0;
                rst_n     = 1'b0;
                req_valid = 1'b0;
                cntrl_in  = '0;
                model_reset();
            end else begin
                drive();
                step();
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
